// File: rtl/imem_responder.sv
// imem_responder: single-port word memory answering one read/write request after a fixed latency,
// with a one-cycle MemReady pulse and AddrErr on misaligned, out-of-range or dual-op requests.
module imem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEn,
  output logic [31:0] MemData,
  output logic        MemReady,
  output logic        Busy,
  output logic        AddrErr
);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d, data_q, data_d;
  logic [3:0]              be_q, be_d;
  logic                    wr_q, wr_d, err_q, err_d, ready_q, ready_d, aerr_q, aerr_d;
  logic                    mem_we;
  logic [31:0]             mem [0:(1<<ADDR_WIDTH)-1];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    err_d   = err_q;
    data_d  = data_q;
    ready_d = 1'b0;
    aerr_d  = 1'b0;
    mem_we  = 1'b0;
    if (state_q == IDLE) begin
      if (MemRead | MemWrite) begin
        state_d = BUSY;
        cnt_d   = 4'(LATENCY - 1);
        addr_d  = Address[ADDR_WIDTH+1:2];
        wdata_d = WriteData;
        be_d    = ByteEn;
        wr_d    = MemWrite;
        err_d   = (MemRead & MemWrite) | (|Address[1:0]) | (|Address[31:ADDR_WIDTH+2]);
      end
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      state_d = IDLE;
      ready_d = 1'b1;
      aerr_d  = err_q;
      mem_we  = wr_q & ~err_q;
      data_d  = (~wr_q & ~err_q) ? mem[addr_q] : data_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 32'd0;
      ready_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      aerr_q  <= aerr_d;
    end
  end
  // Array has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (reset && mem_we)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
  end
  assign MemData  = data_q;
  assign MemReady = ready_q;
  assign Busy     = (state_q == BUSY);
  assign AddrErr  = aerr_q;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed plus randomized requests checked against a word-array reference model.
module tb_imem_responder;
  localparam int ADDR_WIDTH = 10;
  localparam int LATENCY    = 2;
  localparam int POOL       = 16;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] Address = 32'd0, WriteData = 32'd0;
  logic [3:0]  ByteEn = 4'd0;
  logic [31:0] MemData;
  logic        MemReady, Busy, AddrErr;
  int          checks = 0, errors = 0;
  logic [31:0] mdl [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] exp_data = 32'd0;

  imem_responder #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ByteEn(ByteEn),
    .MemData(MemData), .MemReady(MemReady), .Busy(Busy), .AddrErr(AddrErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(MemReady), 32'd0);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_aerr"}, 32'(AddrErr), 32'd0);
    check({tag, "_data"}, MemData, exp_data);
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input logic hold);
    logic fault;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Address = a; WriteData = wd; ByteEn = be;
    @(posedge clk); #1;
    check("accept_busy", 32'(Busy), 32'd1);
    check("accept_ready", 32'(MemReady), 32'd0);
    if (!hold) begin
      MemRead = 1'b0; MemWrite = 1'b0;
      Address = $urandom; WriteData = $urandom; ByteEn = 4'($urandom);
    end
    fault = (rd && wr) || (a % 4 != 0) || (a >= (32'd4 << ADDR_WIDTH));
    if (!fault && rd) exp_data = mdl[a / 4];
    if (!fault && wr)
      for (int i = 0; i < 4; i++) if (be[i]) mdl[a / 4][8*i +: 8] = wd[8*i +: 8];
    repeat (LATENCY - 1) begin
      @(posedge clk); #1;
      check("wait_busy", 32'(Busy), 32'd1);
      check("wait_ready", 32'(MemReady), 32'd0);
    end
    @(posedge clk); #1;
    check("done_ready", 32'(MemReady), 32'd1);
    check("done_busy", 32'(Busy), 32'd0);
    check("done_aerr", 32'(AddrErr), 32'(fault));
    check("done_data", MemData, exp_data);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      check_idle(tag);
    end
  endtask

  initial begin
    logic [31:0] a;
    int r;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk); reset = 1'b1;
    idle_cycles(3, "idle");
    for (int i = 0; i < POOL; i++) txn(1'b0, 1'b1, 32'(i * 4), 32'd0, 4'hF, 1'b0);
    txn(1'b0, 1'b1, 32'h10, 32'h00030D40, 4'hF, 1'b0);
    txn(1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0);
    check("rd_200000", MemData, 32'h00030D40);
    idle_cycles(6, "hold");
    txn(1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 1'b0);
    txn(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, 1'b0);
    check("byte_lanes", MemData, 32'h00BB0DDD);
    txn(1'b1, 1'b0, 32'h13, 32'd0, 4'hF, 1'b0);
    txn(1'b1, 1'b0, 32'h1000, 32'd0, 4'hF, 1'b0);
    txn(1'b1, 1'b1, 32'h10, 32'h12345678, 4'hF, 1'b0);
    txn(1'b0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, 1'b0);
    txn(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, 1'b1);
    txn(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, 1'b0);
    check("dual_op_unchanged", MemData, 32'h00BB0DDD);
    idle_cycles(1, "b2b_end");
    @(negedge clk);
    MemWrite = 1'b1; Address = 32'h20; WriteData = 32'hDEADBEEF; ByteEn = 4'hF;
    @(posedge clk); #1;
    check("abort_busy", 32'(Busy), 32'd1);
    MemWrite = 1'b0;
    repeat (LATENCY - 1) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    exp_data = 32'd0;
    @(posedge clk); #1;
    check_idle("abort");
    @(negedge clk); reset = 1'b1;
    idle_cycles(2, "post_abort");
    txn(1'b1, 1'b0, 32'h20, 32'd0, 4'hF, 1'b0);
    check("abort_no_write", MemData, 32'd0);
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 99));
      a = 32'($urandom_range(0, POOL - 1) * 4);
      if (r < 8) a = a + 32'($urandom_range(1, 3));
      else if (r < 14) a = a + (32'd4 << ADDR_WIDTH) + (32'd1 << $urandom_range(0, 19));
      r = int'($urandom_range(0, 99));
      txn(r < 50, r >= 45, a, $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
    end
    idle_cycles(2, "final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
